reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the CPU's general-purpose register file.
- Adds N read ports and two write ports: port A is the in-order ALU writeback; port B is the late load / mul-div writeback.
- Adds optional write-through bypass, a reset-cleared array, and a per-register busy scoreboard with a pending counter. Issue logic uses the scoreboard to stall on unresolved load results.
- Sits in decode (reads), writeback (writes) and issue (reserve).

Parameters:
- WORD_WIDTH, 32: data width of every register.
- ADDR_WIDTH, 5: register index width; NUM_REGS = 2**ADDR_WIDTH.
- NUM_READ, 2: number of independent read ports, 1..4.
- BYPASS, 1: 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value only.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes and ignores reservations.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- rdAddr, input, NUM_READ*ADDR_WIDTH: packed read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdData, output, NUM_READ*WORD_WIDTH: packed read data, combinational.
- rdBusy, output, NUM_READ: 1 = the addressed register has a pending port-B write.
- wrEnA, input, 1: port A write enable.
- wrAddrA, input, ADDR_WIDTH: port A write address.
- wrDataA, input, WORD_WIDTH: port A write data.
- wrEnB, input, 1: port B write enable; also clears busy on the addressed register.
- wrAddrB, input, ADDR_WIDTH: port B write address.
- wrDataB, input, WORD_WIDTH: port B write data.
- reserveEn, input, 1: marks reserveAddr busy for a future port-B write.
- reserveAddr, input, ADDR_WIDTH: register to reserve.
- pendingCount, output, ADDR_WIDTH+1: number of busy registers, registered.

Behaviour:
- Reset (rst=1, async):
  - All registers cleared to 0; all busy bits 0; pendingCount=0.
  - Reads during and after reset return 0.
  - Writes and reserves on the release edge are applied normally.
- Writes:
  - Applied at posedge clk when the enable is high.
  - Same address on both ports in one cycle: port A data is stored (younger instruction wins); the busy clear from port B still happens.
  - Address 0 with ZERO_REG=1: write dropped.
- Reads: combinational, zero latency.
  - rdData[i] = 0 if ZERO_REG and addr 0.
  - Else, if BYPASS and wrEnA and wrAddrA==addr: wrDataA.
  - Else, if BYPASS and wrEnB and wrAddrB==addr: wrDataB.
  - Else the stored value.
  - BYPASS=0: stored value only; new data is visible the cycle after the edge.
- Scoreboard:
  - busy[r] set at posedge when reserveEn and reserveAddr==r.
  - busy[r] cleared at posedge when wrEnB and wrAddrB==r.
  - Simultaneous set and clear on the same r: set wins (new reservation overrides the completing one).
  - Reserve of an already-busy register: stays busy; count unchanged.
  - Port-B write to a non-busy register: data written; busy unchanged.
  - Port-A write does not affect busy.
  - Register 0 with ZERO_REG=1: never busy.
- rdBusy[i] = busy[addr], forced 0 when BYPASS and wrEnB writes that addr this cycle (its data is already forwarded), and forced 0 for addr 0 when ZERO_REG=1.
- pendingCount: registered; next value = current + (reserve sets a previously clear bit) - (port B clears a previously set bit, not overridden by a set). Range 0..NUM_REGS (or NUM_REGS-1 with ZERO_REG); never wraps.
- Read ports are independent; any ports may share an address.
- No X propagation: unused read ports with any address still return a defined stored value.

Test Plan:
- Assert rst mid-run after writing r5=0x1234 and reserving r7 -> rdData r5=0 immediately (async), rdBusy r7=0, pendingCount=0.
- wrEnA r3=0xDEADBEEF while reading r3, BYPASS=1 -> same-cycle rdData=0xDEADBEEF; with BYPASS=0 -> old value 0, then 0xDEADBEEF next cycle.
- Write r0=0xFFFFFFFF on both ports plus reserve r0 -> read r0=0, rdBusy=0, pendingCount=0.
- Same cycle wrEnA r9=0x11 and wrEnB r9=0x22 with r9 busy -> stored 0x11, busy r9 cleared, pendingCount decrements 1->0.
- Reserve r4; next cycle wrEnB r4 and reserveEn r4 simultaneously -> r4 stays busy, pendingCount stays 1; reserve r4,r5,r6 sequentially -> pendingCount 1,2,3.
- Four read ports (NUM_READ=4) on addresses 1,1,2,31 after writes 0xA,0xB to r1,r2 -> 0xA,0xA,0xB,0.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write bypass and a port-B busy scoreboard.
module reg_file_sb #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rdAddr,
    output logic [NUM_READ*WORD_WIDTH-1:0] rdData,
    output logic [NUM_READ-1:0]            rdBusy,
    input  logic                           wrEnA,
    input  logic [ADDR_WIDTH-1:0]          wrAddrA,
    input  logic [WORD_WIDTH-1:0]          wrDataA,
    input  logic                           wrEnB,
    input  logic [ADDR_WIDTH-1:0]          wrAddrB,
    input  logic [WORD_WIDTH-1:0]          wrDataB,
    input  logic                           reserveEn,
    input  logic [ADDR_WIDTH-1:0]          reserveAddr,
    output logic [ADDR_WIDTH:0]            pendingCount
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_wr_a, w_wr_b, w_set, w_inc, w_dec;
    logic [NUM_REGS-1:0]   w_busy_nxt;

    assign w_wr_a = wrEnA && !(ZERO_REG != 0 && wrAddrA == '0);
    assign w_wr_b = wrEnB && !(ZERO_REG != 0 && wrAddrB == '0);
    assign w_set  = reserveEn && !(ZERO_REG != 0 && reserveAddr == '0);
    assign w_inc  = w_set && !r_busy[reserveAddr];
    // a completing port-B write only retires the entry if no new reservation reclaims it
    assign w_dec  = wrEnB && r_busy[wrAddrB] && !(w_set && reserveAddr == wrAddrB);
    assign w_busy_nxt = (r_busy & ~(NUM_REGS'(wrEnB) << wrAddrB)) | (NUM_REGS'(w_set) << reserveAddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_b) r_regs[wrAddrB] <= wrDataB;
            if (w_wr_a) r_regs[wrAddrA] <= wrDataA;
            r_busy  <= w_busy_nxt;
            r_count <= r_count + (ADDR_WIDTH+1)'(w_inc) - (ADDR_WIDTH+1)'(w_dec);
        end
    end

    assign pendingCount = r_count;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_a;
        logic                  w_zero, w_hit_a, w_hit_b;
        assign w_a     = rdAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_zero  = ZERO_REG != 0 && w_a == '0;
        assign w_hit_a = BYPASS != 0 && !rst && wrEnA && wrAddrA == w_a;
        assign w_hit_b = BYPASS != 0 && !rst && wrEnB && wrAddrB == w_a;
        assign rdData[i*WORD_WIDTH +: WORD_WIDTH] = w_zero ? '0 : w_hit_a ? wrDataA : w_hit_b ? wrDataB : r_regs[w_a];
        assign rdBusy[i] = r_busy[w_a] && !w_hit_b && !w_zero;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: random and directed checks of reg_file_sb (bypass and non-bypass) against a behavioural model.
module tb_reg_file_sb;
    logic         clk = 0;
    logic         rst = 0;
    logic [19:0]  rdAddr = '0;
    logic         wrEnA = 0, wrEnB = 0, reserveEn = 0;
    logic [4:0]   wrAddrA = '0, wrAddrB = '0, reserveAddr = '0;
    logic [31:0]  wrDataA = '0, wrDataB = '0;
    logic [127:0] d1, d0;
    logic [3:0]   b1, b0;
    logic [5:0]   c1, c0;
    logic [31:0]  m_mem [32];
    logic [31:0]  m_busy;
    bit           chk_en = 0;
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.WORD_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4), .BYPASS(1), .ZERO_REG(1)) u_byp (
        .clk(clk), .rst(rst), .rdAddr(rdAddr), .rdData(d1), .rdBusy(b1),
        .wrEnA(wrEnA), .wrAddrA(wrAddrA), .wrDataA(wrDataA),
        .wrEnB(wrEnB), .wrAddrB(wrAddrB), .wrDataB(wrDataB),
        .reserveEn(reserveEn), .reserveAddr(reserveAddr), .pendingCount(c1));

    reg_file_sb #(.WORD_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4), .BYPASS(0), .ZERO_REG(1)) u_nobyp (
        .clk(clk), .rst(rst), .rdAddr(rdAddr), .rdData(d0), .rdBusy(b0),
        .wrEnA(wrEnA), .wrAddrA(wrAddrA), .wrDataA(wrDataA),
        .wrEnB(wrEnB), .wrAddrB(wrAddrB), .wrDataB(wrDataB),
        .reserveEn(reserveEn), .reserveAddr(reserveAddr), .pendingCount(c0));

    // Architectural state: port A overrides port B data; a reservation overrides a completion.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) m_mem[k] <= '0;
            m_busy <= '0;
        end else begin
            if (wrEnB && wrAddrB != 0) m_mem[wrAddrB] <= wrDataB;
            if (wrEnA && wrAddrA != 0) m_mem[wrAddrA] <= wrDataA;
            if (wrEnB) m_busy[wrAddrB] <= 1'b0;
            if (reserveEn && reserveAddr != 0) m_busy[reserveAddr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_d(logic [4:0] a, bit byp);
        if (a == 0) return '0;
        if (byp && !rst && wrEnA && wrAddrA == a) return wrDataA;
        if (byp && !rst && wrEnB && wrAddrB == a) return wrDataB;
        return m_mem[a];
    endfunction

    function automatic logic exp_b(logic [4:0] a, bit byp);
        return a != 0 && m_busy[a] && !(byp && wrEnB && wrAddrB == a);
    endfunction

    task automatic cmp(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < 4; p++) begin
                cmp($sformatf("rd_byp[%0d]", p), 128'(d1[p*32 +: 32]), 128'(exp_d(rdAddr[p*5 +: 5], 1)));
                cmp($sformatf("rd_nobyp[%0d]", p), 128'(d0[p*32 +: 32]), 128'(exp_d(rdAddr[p*5 +: 5], 0)));
                cmp($sformatf("busy_byp[%0d]", p), 128'(b1[p]), 128'(exp_b(rdAddr[p*5 +: 5], 1)));
                cmp($sformatf("busy_nobyp[%0d]", p), 128'(b0[p]), 128'(exp_b(rdAddr[p*5 +: 5], 0)));
            end
            cmp("count_byp", 128'(c1), 128'($countones(m_busy)));
            cmp("count_nobyp", 128'(c0), 128'($countones(m_busy)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wrEnA = 0; wrEnB = 0; reserveEn = 0;
    endtask

    task automatic setrd(int p, logic [4:0] a);
        rdAddr[p*5 +: 5] = a;
    endtask

    function automatic logic [31:0] rd(logic [127:0] d, int p);
        return d[p*32 +: 32];
    endfunction

    initial begin
        #1 rst = 1;
        #1 chk_en = 1;
        setrd(0, 5);
        #1;
        cmp("reset_data", 128'(rd(d1, 0)), 128'h0);
        cmp("reset_count", 128'(c1), 128'h0);
        @(posedge clk); #1 rst = 0;
        // write-through versus registered visibility
        step(); wrEnA = 1; wrAddrA = 3; wrDataA = 32'hDEADBEEF; setrd(0, 3);
        #1;
        cmp("bypass_same_cycle", 128'(rd(d1, 0)), 128'hDEADBEEF);
        cmp("nobypass_old", 128'(rd(d0, 0)), 128'h0);
        step(); #1;
        cmp("nobypass_next", 128'(rd(d0, 0)), 128'hDEADBEEF);
        // register zero
        step(); wrEnA = 1; wrAddrA = 0; wrDataA = '1; wrEnB = 1; wrAddrB = 0; wrDataB = '1;
        reserveEn = 1; reserveAddr = 0; setrd(0, 0);
        #1;
        cmp("r0_data", 128'(rd(d1, 0)), 128'h0);
        cmp("r0_busy", 128'(b1[0]), 128'h0);
        step(); #1;
        cmp("r0_count", 128'(c1), 128'h0);
        cmp("r0_data_after", 128'(rd(d0, 0)), 128'h0);
        // dual write to a busy register
        step(); reserveEn = 1; reserveAddr = 9;
        step(); setrd(0, 9); #1;
        cmp("r9_busy", 128'(b1[0]), 128'h1);
        cmp("r9_count1", 128'(c1), 128'h1);
        wrEnA = 1; wrAddrA = 9; wrDataA = 32'h11; wrEnB = 1; wrAddrB = 9; wrDataB = 32'h22;
        #1;
        cmp("r9_fwd_a_wins", 128'(rd(d1, 0)), 128'h11);
        cmp("r9_fwd_busy", 128'(b1[0]), 128'h0);
        cmp("r9_nobyp_busy", 128'(b0[0]), 128'h1);
        step(); #1;
        cmp("r9_stored", 128'(rd(d0, 0)), 128'h11);
        cmp("r9_count0", 128'(c1), 128'h0);
        cmp("r9_cleared", 128'(b0[0]), 128'h0);
        // reservation overriding completion, then accumulation
        step(); reserveEn = 1; reserveAddr = 4;
        step(); wrEnB = 1; wrAddrB = 4; wrDataB = 32'h44; reserveEn = 1; reserveAddr = 4;
        step(); setrd(0, 4); #1;
        cmp("r4_count", 128'(c1), 128'h1);
        cmp("r4_busy", 128'(b1[0]), 128'h1);
        cmp("r4_data", 128'(rd(d0, 0)), 128'h44);
        reserveEn = 1; reserveAddr = 5;
        step(); #1;
        cmp("count2", 128'(c1), 128'h2);
        reserveEn = 1; reserveAddr = 6;
        step(); #1;
        cmp("count3", 128'(c1), 128'h3);
        // four read ports sharing addresses
        step(); wrEnA = 1; wrAddrA = 1; wrDataA = 32'hA; wrEnB = 1; wrAddrB = 2; wrDataB = 32'hB;
        step(); rdAddr = {5'd31, 5'd2, 5'd1, 5'd1}; #1;
        cmp("four_ports", d1, {32'h0, 32'hB, 32'hA, 32'hA});
        // asynchronous reset mid-run
        step(); wrEnA = 1; wrAddrA = 5; wrDataA = 32'h1234; reserveEn = 1; reserveAddr = 7;
        step(); setrd(0, 5); setrd(1, 7); #1;
        cmp("pre_rst_data", 128'(rd(d0, 0)), 128'h1234);
        cmp("pre_rst_busy", 128'(b0[1]), 128'h1);
        rst = 1; #1;
        cmp("async_rst_data", 128'(rd(d1, 0)), 128'h0);
        cmp("async_rst_busy", 128'(b1[1]), 128'h0);
        cmp("async_rst_count", 128'(c1), 128'h0);
        step(); rst = 0;
        // random traffic, addresses biased toward a small window to force collisions
        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            wrEnA = $urandom_range(0, 1);
            wrEnB = $urandom_range(0, 2) == 0;
            reserveEn = $urandom_range(0, 2) == 0;
            wrAddrA = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wrAddrB = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            reserveAddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wrDataA = $urandom;
            wrDataB = $urandom;
            for (int p = 0; p < 4; p++)
                setrd(p, ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)));
        end
        step(); rst = 0;
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
